// File: rtl/imem_arbiter.sv
// Arbitrates one single-ported instruction memory between fetch (port A) and loader (port B), with a B lock.
// Define IMEM_ARB_RR_EN for round-robin contention; otherwise fetch has fixed priority.
module imem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_req,
    input  logic [ADDR_W-1:0]   a_addr,
    output logic                a_gnt,
    output logic                a_rvalid,
    output logic [DATA_W-1:0]   a_rdata,
    input  logic                b_req,
    input  logic                b_we,
    input  logic                b_lock,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_wdata,
    input  logic [DATA_W/8-1:0] b_wstrb,
    output logic                b_gnt,
    output logic                b_rvalid,
    output logic [DATA_W-1:0]   b_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata
);

    typedef enum logic {ARB, LOCK_B} state_t;

    state_t state_q, state_d;
    logic   a_wins;

`ifdef IMEM_ARB_RR_EN
    // Set when A was granted most recently; B wins the next contention.
    logic last_a_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_a_q <= 1'b1;
        end else if (a_gnt) begin
            last_a_q <= 1'b1;
        end else if (b_gnt) begin
            last_a_q <= 1'b0;
        end
    end

    assign a_wins = !last_a_q;
`else
    assign a_wins = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:    if (b_gnt && b_lock)  state_d = LOCK_B;
            LOCK_B: if (b_gnt && !b_lock) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // Grants are gated by rst_n so nothing reaches the memory while reset is held.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (rst_n) begin
            if (state_q == LOCK_B) begin
                b_gnt = b_req;
            end else if (a_req && b_req) begin
                a_gnt = a_wins;
                b_gnt = !a_wins;
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    always_comb begin
        mem_en    = a_gnt | b_gnt;
        mem_we    = b_gnt & b_we;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (b_gnt) begin
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
            if (b_we) mem_wstrb = b_wstrb;
        end else if (a_gnt) begin
            mem_addr = a_addr;
        end
    end

    // Response tag: one flop per port marks who issued last cycle's read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= a_gnt;
            b_rvalid <= b_gnt & ~b_we;
        end
    end

    assign a_rdata = mem_rdata;
    assign b_rdata = mem_rdata;

endmodule
